// File: rtl/sync_debounce.sv
// Debounce and edge-detect stage: accepts a new level only after it has been stable for thres_i+2 samples.
// Optional macro SYNC_DEBOUNCE_INT_SYNC_EN adds a 2-flop input synchronizer (two extra cycles of latency).
module sync_debounce #(
    parameter int         CNT_WIDTH = 16,
    parameter logic [0:0] RST_VAL   = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] thres_i,
    input  logic                 dat_i,
    output logic                 dat_o,
    output logic                 rise_o,
    output logic                 fall_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        S_STB0 = 2'd0,
        S_CHK1 = 2'd1,
        S_STB1 = 2'd2,
        S_CHK0 = 2'd3
    } state_t;

    localparam state_t S_RST = (RST_VAL == 1'b1) ? S_STB1 : S_STB0;

    logic w_dat;

`ifdef SYNC_DEBOUNCE_INT_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_sync <= {2{RST_VAL}};
        else          r_sync <= {r_sync[0], dat_i};
    end

    assign w_dat = r_sync[1];
`else
    assign w_dat = dat_i;
`endif

    state_t               r_state, w_state_nx;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nx;
    logic                 r_dat, w_dat_nx;
    logic                 r_rise, w_rise_nx;
    logic                 r_fall, w_fall_nx;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_RST;
            r_cnt   <= '0;
            r_dat   <= RST_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_dat   <= w_dat_nx;
            r_rise  <= w_rise_nx;
            r_fall  <= w_fall_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_dat_nx   = r_dat;
        w_rise_nx  = 1'b0;
        w_fall_nx  = 1'b0;
        case (r_state)
            S_STB0: begin
                if (en_i && w_dat) begin
                    w_state_nx = S_CHK1;
                    w_cnt_nx   = '0;
                end
            end
            S_CHK1: begin
                if (!en_i || !w_dat) begin
                    w_state_nx = S_STB0;
                    w_cnt_nx   = '0;
                end else if (r_cnt >= thres_i) begin
                    // >= rather than == so a threshold lowered mid-check accepts at once
                    w_state_nx = S_STB1;
                    w_dat_nx   = 1'b1;
                    w_rise_nx  = 1'b1;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_WIDTH'(1);
                end
            end
            S_STB1: begin
                if (en_i && !w_dat) begin
                    w_state_nx = S_CHK0;
                    w_cnt_nx   = '0;
                end
            end
            S_CHK0: begin
                if (!en_i || w_dat) begin
                    w_state_nx = S_STB1;
                    w_cnt_nx   = '0;
                end else if (r_cnt >= thres_i) begin
                    w_state_nx = S_STB0;
                    w_dat_nx   = 1'b0;
                    w_fall_nx  = 1'b1;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                w_state_nx = S_RST;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign dat_o  = r_dat;
    assign rise_o = r_rise;
    assign fall_o = r_fall;
    assign busy_o = (r_state == S_CHK1) || (r_state == S_CHK0);

endmodule
